// File: rtl/autobaud_meter.sv
// Measures the bit period of a 0x55 sync character on rx, averaging 2^AVG_LOG2 intervals.
// The truncated mean is published on N in clk cycles per bit.
//
// state     | meaning
// IDLE      | waiting for start
// ARM       | armed, waiting for the line to be idle high
// WAIT_FALL | line idle, waiting for the start-bit falling edge
// MEASURE   | timing bit intervals between successive rx edges
module autobaud_meter #(
    parameter int CNT_W    = 16,
    parameter int AVG_LOG2 = 2,
    parameter int MIN_CNT  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             rx,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] N
);

    localparam int               ACC_W   = CNT_W + AVG_LOG2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_CNT);
    localparam logic [3:0]       K_LAST  = 4'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {IDLE, ARM, WAIT_FALL, MEASURE} state_t;

    state_t             state_q, state_d;
    logic               rx_q, rx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   acc_sum;
    logic [3:0]         k_q, k_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               rx_edge;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            rx_q    <= 1'b1;
            cnt_q   <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            n_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            n_q     <= n_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rx_d    = rx;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        k_d     = k_q;
        n_d     = n_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rx_edge = (rx != rx_q);
        acc_sum = acc_q + ACC_W'(cnt_q);

        // start overrides everything, including a terminating edge in the same cycle
        if (start) begin
            state_d = ARM;
            cnt_d   = '0;
            acc_d   = '0;
            k_d     = '0;
        end else begin
            case (state_q)
                IDLE: ;
                ARM: begin
                    if (rx) state_d = WAIT_FALL;
                end
                WAIT_FALL: begin
                    if (rx_q && !rx) begin
                        state_d = MEASURE;
                        cnt_d   = CNT_W'(1);
                        acc_d   = '0;
                        k_d     = '0;
                    end
                end
                MEASURE: begin
                    if (rx_edge) begin
                        if (cnt_q < CNT_MIN) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            acc_d = acc_sum;
                            cnt_d = CNT_W'(1);
                            k_d   = k_q + 4'd1;
                            if (k_q == K_LAST) begin
                                n_d     = CNT_W'(acc_sum >> AVG_LOG2);
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign err  = err_q;
    assign N    = n_q;

endmodule

// File: tb/tb_autobaud_meter.sv
// Scoreboarded bench for autobaud_meter: stimulus queues expected done/err events,
// a negedge monitor pops and compares them whenever the DUT pulses done or err.
module tb_autobaud_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        rx = 1'b1;
    logic        busy, done, err;
    logic [15:0] N;

    autobaud_meter #(.CNT_W(16), .AVG_LOG2(2), .MIN_CNT(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .rx    (rx),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .N     (N)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_err;
        logic [15:0] n;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   fc;

    task automatic check(string name, int act, int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic level(logic v, int n);
        rx = v;
        repeat (n) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic expect_evt(bit is_err, logic [15:0] n, int at);
        exp_t e;
        e.is_err = is_err;
        e.n      = n;
        e.at     = at;
        sb.push_back(e);
    endtask

    // start bit, data bits 0x55 LSB first, stop bit
    task automatic send_55(int p);
        level(1'b0, p);
        for (int i = 0; i < 8; i++) level((i % 2 == 0) ? 1'b1 : 1'b0, p);
        level(1'b1, p);
    endtask

    always @(negedge clk) begin
        if (rst && (done || err)) begin
            check("done_and_err_together", int'(done & err), 0);
            check("busy_at_end", int'(busy), 0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: done=%0d err=%0d N=%0d at cycle %0d, expected no event",
                         done, err, N, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("event_is_err", int'(err), int'(mon_e.is_err));
                check("N_value", int'(N), int'(mon_e.n));
                check("event_cycle", cyc, mon_e.at);
            end
        end
    end

    initial begin
        rst = 1'b0;
        rx  = 1'b1;
        repeat (3) tick();
        check("reset_N", int'(N), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_err", int'(err), 0);
        rst = 1'b1;
        tick();

        // nominal 16 cycles/bit
        pulse_start();
        check("busy_after_start", int'(busy), 1);
        level(1'b1, 4);
        check("busy_wait_fall", int'(busy), 1);
        fc = cyc + 1;
        expect_evt(1'b0, 16'd16, fc + 64);
        send_55(16);
        level(1'b1, 10);
        check("pending_nominal", sb.size(), 0);

        // jitter 15,17,16,18 -> 66>>2 = 16
        pulse_start();
        level(1'b1, 4);
        fc = cyc + 1;
        expect_evt(1'b0, 16'd16, fc + 66);
        level(1'b0, 15);
        level(1'b1, 17);
        level(1'b0, 16);
        level(1'b1, 18);
        level(1'b0, 16);
        level(1'b1, 20);
        check("pending_jitter", sb.size(), 0);

        // glitch of 2 cycles
        pulse_start();
        level(1'b1, 4);
        fc = cyc + 1;
        expect_evt(1'b1, 16'd16, fc + 2);
        level(1'b0, 2);
        level(1'b1, 10);
        check("busy_after_glitch2", int'(busy), 0);
        check("pending_glitch2", sb.size(), 0);

        // glitch of 3 cycles, one below the minimum
        pulse_start();
        level(1'b1, 4);
        fc = cyc + 1;
        expect_evt(1'b1, 16'd16, fc + 3);
        level(1'b0, 3);
        level(1'b1, 10);
        check("pending_glitch3", sb.size(), 0);

        // timeout with rx held low
        pulse_start();
        level(1'b1, 4);
        fc = cyc + 1;
        expect_evt(1'b1, 16'd16, fc + 65535);
        level(1'b0, 65540);
        check("busy_after_timeout", int'(busy), 0);
        level(1'b1, 10);
        check("pending_timeout", sb.size(), 0);

        // intervals exactly at the minimum: 4,4,5,4 -> 17>>2 = 4
        pulse_start();
        level(1'b1, 3);
        fc = cyc + 1;
        expect_evt(1'b0, 16'd4, fc + 17);
        level(1'b0, 4);
        level(1'b1, 4);
        level(1'b0, 5);
        level(1'b1, 4);
        level(1'b0, 4);
        level(1'b1, 10);
        check("pending_min", sb.size(), 0);

        // restart after the second interval, then 0x55 at 32
        pulse_start();
        level(1'b1, 4);
        level(1'b0, 16);
        level(1'b1, 16);
        level(1'b0, 3);
        pulse_start();
        check("busy_after_restart", int'(busy), 1);
        level(1'b0, 5);
        level(1'b1, 40);
        fc = cyc + 1;
        expect_evt(1'b0, 16'd32, fc + 128);
        send_55(32);
        level(1'b1, 10);
        check("pending_restart", sb.size(), 0);

        // start coincides with the terminating edge
        pulse_start();
        level(1'b1, 4);
        level(1'b0, 20);
        level(1'b1, 20);
        level(1'b0, 20);
        level(1'b1, 20);
        rx    = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start_wins", int'(busy), 1);
        level(1'b0, 5);
        level(1'b1, 10);
        fc = cyc + 1;
        expect_evt(1'b0, 16'd20, fc + 80);
        send_55(20);
        level(1'b1, 10);
        check("pending_start_wins", sb.size(), 0);

        // armed while the line is low: the first rise is not measured
        level(1'b0, 5);
        pulse_start();
        level(1'b0, 10);
        check("busy_armed_low", int'(busy), 1);
        level(1'b1, 10);
        fc = cyc + 1;
        expect_evt(1'b0, 16'd24, fc + 96);
        send_55(24);
        level(1'b1, 10);
        check("pending_armed_low", sb.size(), 0);

        // reset mid-measurement, then 0x55 without start
        pulse_start();
        level(1'b1, 4);
        level(1'b0, 16);
        level(1'b1, 8);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midreset_N", int'(N), 0);
        check("midreset_busy", int'(busy), 0);
        level(1'b1, 8);
        send_55(16);
        level(1'b1, 10);
        check("busy_no_start", int'(busy), 0);
        check("pending_final", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/autobaud_meter.md
# autobaud_meter

Parametrised baud-rate measurement block for the UART receiver. It times the bit period of an incoming sync character 0x55 ('U') on the serial line, averaging 2^AVG_LOG2 consecutive bit intervals, and publishes the result as divisor N in clock cycles per bit. It rejects glitches and timeouts, and sits between the RX input synchroniser and the baud-rate generator's divisor register.

## Interface
Parameters:
- CNT_W, 16: width of the interval counter and of N.
- AVG_LOG2, 2: log2 of the number of bit intervals averaged; legal range 0..3, since 0x55 yields at most 9 intervals.
- MIN_CNT, 4: shortest legal interval in cycles; anything shorter is a glitch.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse that arms a measurement.
- rx  in  1  serial line, idle high, already synchronised to clk.
- busy  out  1  high while armed or measuring.
- done  out  1  one-cycle pulse when N is updated.
- err  out  1  one-cycle pulse when a measurement is aborted by a glitch or timeout.
- N  out  CNT_W  averaged bit period in clk cycles; held between measurements.

## Operation
- Edge detect: rx_q is rx registered. An edge is rx != rx_q.
- FSM states: IDLE, ARM, WAIT_FALL, MEASURE.
- IDLE: when start=1, go to ARM.
- ARM: wait for rx=1 (line idle), then go to WAIT_FALL. There is no timeout.
- WAIT_FALL: on a falling edge (rx_q=1, rx=0), go to MEASURE. Load cnt=1, acc=0, k=0.
- MEASURE, cycle with no edge: cnt <= cnt+1.
- MEASURE, cycle with an edge: the interval equals cnt.
  - If cnt < MIN_CNT: err, go to IDLE.
  - Otherwise acc <= acc+cnt, cnt <= 1, k <= k+1.
  - If this is interval number 2^AVG_LOG2: N <= (acc+cnt) >> AVG_LOG2, done, go to IDLE.
- Timeout: in MEASURE, if cnt reaches 2^CNT_W-1 with no edge, raise err and go to IDLE. cnt never wraps.
- acc is CNT_W+AVG_LOG2 bits wide, so it cannot overflow. N is truncated, never rounded.
- busy=1 exactly in ARM, WAIT_FALL and MEASURE.
- start while busy: abort and restart at ARM. acc, cnt and k are discarded; N is unchanged and no err is raised.
- On err, N keeps its previous value. On done, N takes the new value.
- If start and a terminating edge occur in the same cycle, start wins: restart at ARM with no done and no err.

## Timing
- Reset (rst=0 at a clock edge): state=IDLE, N=0, done=0, err=0, busy=0, rx_q=1, cnt=0, acc=0, k=0.
- Reset mid-measurement discards all progress. A new start is required afterwards.
- Interval definition: edge sampled at clock edge t0, next edge sampled at t1, interval = t1 - t0 cycles.
- Result latency: N and done update on the clock edge that samples the final transition. done is high for exactly that following cycle.
- busy falls on that same edge.
- err has the same timing as done: a one-cycle pulse, with busy falling together.
- done and err are never high together.
- Minimum start-to-busy latency is 1 cycle.
- A falling edge can be taken no earlier than the first cycle after ARM sees rx=1.

## Test plan
Bench parameters for all scenarios: CNT_W=16, AVG_LOG2=2, MIN_CNT=4.
- Nominal: idle line, start, then 0x55 at 16 cycles/bit → done exactly once, N=16, err=0. busy is high from the cycle after start until done.
- Jitter and truncation: first four intervals of 15, 17, 16, 18 cycles → N=16 (66>>2).
- Glitch: after the falling edge, rx returns high after 2 cycles → err pulse, N keeps its prior value (16), busy=0, no done.
- Timeout: after the falling edge, hold rx low → err exactly 65535 cycles after the edge, N unchanged.
- Restart and reset:
  - start pulse after the second interval → no done or err; the next 0x55 at 32 cycles/bit gives N=32.
  - rst=0 mid-MEASURE → N=0, busy=0, state IDLE. A later 0x55 without start produces no done.
- Armed on low line: start while rx=0 → the first rise is not measured. With a 0x55 following, measurement starts at its start-bit fall and N equals the bit period.
